// File: rtl/hdmi_data_island_decoder.sv
// HDMI data-island packet decoder.
// Consumes TERC4-decoded data-island nibbles, reassembles the 24-bit header
// and four 56-bit subpackets of each 32-pixel packet, checks their BCH
// parity, and extracts ACR (CTS/N) values and stereo audio samples.
//
// Ports:
//   i_pixclk      pixel clock, all logic on its rising edge
//   i_reset       synchronous active-high reset
//   i_data        high during data-island pixels
//   i_d0/d1/d2    decoded nibbles of TMDS channels 0/1/2
//   o_hsync/vsync i_d0[0]/i_d0[1] registered during islands, held otherwise
//   o_pkt_valid   one-cycle strobe per completed packet
//   o_pkt_header  received header, HB0 in [7:0]
//   o_hdr_err     header parity mismatch
//   o_sub_err     per-subpacket parity mismatch
//   o_acr_valid   strobe with o_cts / o_n for a clean ACR packet
//   o_audio_valid strobe with one stereo sample on o_audio_l / o_audio_r
module hdmi_data_island_decoder #(
  parameter logic [7:0] ACR_TYPE   = 8'h01,
  parameter logic [7:0] AUDIO_TYPE = 8'h02
) (
  input  logic        i_pixclk,
  input  logic        i_reset,
  input  logic        i_data,
  input  logic [3:0]  i_d0,
  input  logic [3:0]  i_d1,
  input  logic [3:0]  i_d2,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_pkt_valid,
  output logic [23:0] o_pkt_header,
  output logic        o_hdr_err,
  output logic [3:0]  o_sub_err,
  output logic        o_acr_valid,
  output logic [19:0] o_cts,
  output logic [19:0] o_n,
  output logic        o_audio_valid,
  output logic [15:0] o_audio_l,
  output logic [15:0] o_audio_r
);

  typedef enum logic {IDLE, EMIT} emitState_t;

  function automatic logic [7:0] bchStep(input logic [7:0] code, input logic b);
    return {code[6:0], 1'b0} ^ ((code[7] ^ b) ? 8'hC1 : 8'h00);
  endfunction

  // Packet capture state
  logic        dataPrev;
  logic        live;
  logic [4:0]  pixCnt;
  logic [23:0] hdrBits;
  logic [7:0]  hdrCode;
  logic [6:0]  hdrPar;
  logic [55:0] subBits [4];
  logic [7:0]  subCode [4];
  logic [5:0]  subPar  [4];

  // Audio emitter queue
  logic [15:0] qL [4];
  logic [15:0] qR [4];
  logic [3:0]  qMask;
  emitState_t  state, stateNext;

  // Combinational decode
  logic        rise, active, lastPix;
  logic [4:0]  curPix;
  logic [7:0]  hdrCodeNext;
  logic [7:0]  subCodeNext [4];
  logic        hdrErr;
  logic [3:0]  subErr;
  logic        isAcr;
  logic [3:0]  loadMask;
  logic        emitHit;
  logic [1:0]  emitIdx;
  logic [3:0]  maskAfter;
  logic        unusedBits;

  always_comb begin
    rise    = i_data & ~dataPrev;
    active  = i_data & (rise | live);
    curPix  = rise ? 5'd0 : pixCnt + 5'd1;
    lastPix = active && (curPix == 5'd31);
    // Pixel 0 of every packet (fresh island or wrap) restarts the LFSRs.
    hdrCodeNext = bchStep((curPix == 5'd0) ? 8'h00 : hdrCode, i_d0[2]);
    // Final parity bit arrives on pixel 31 itself, so compare against it live.
    hdrErr = {hdrPar, i_d0[2]} != hdrCode;
    for (int unsigned k = 0; k < 4; k++) begin
      subCodeNext[k] = bchStep(bchStep((curPix == 5'd0) ? 8'h00 : subCode[k], i_d1[k]), i_d2[k]);
      subErr[k]      = {subPar[k], i_d1[k], i_d2[k]} != subCode[k];
    end
    isAcr    = (hdrBits[7:0] == ACR_TYPE) && !hdrErr && !subErr[0];
    loadMask = ((hdrBits[7:0] == AUDIO_TYPE) && !hdrErr) ? (hdrBits[11:8] & ~subErr) : 4'b0000;
  end

  // Bits never needed downstream: SB0 of each subpacket, and the audio
  // status bytes of subpackets 1..3.
  always_comb begin
    unusedBits = i_d0[3];
    for (int unsigned k = 0; k < 4; k++)
      unusedBits = unusedBits ^ (^subBits[k][7:0]) ^ (^subBits[k][31:24]) ^ (^subBits[k][55:48]);
  end

  always_comb begin
    stateNext = state;
    emitHit   = 1'b0;
    emitIdx   = 2'd0;
    maskAfter = qMask;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!emitHit && qMask[k]) begin
        emitHit = 1'b1;
        emitIdx = 2'(k);
      end
    end
    case (state)
      IDLE: stateNext = IDLE;
      EMIT: begin
        maskAfter[emitIdx] = 1'b0;
        if (maskAfter == 4'b0000) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (lastPix && (loadMask != 4'b0000)) stateNext = EMIT;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      // Seeding with the live input means an island already in progress at
      // release is ignored; decoding waits for a genuine rise.
      dataPrev      <= i_data;
      live          <= 1'b0;
      pixCnt        <= '0;
      hdrBits       <= '0;
      hdrCode       <= '0;
      hdrPar        <= '0;
      qMask         <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        subBits[k] <= '0;
        subCode[k] <= '0;
        subPar[k]  <= '0;
        qL[k]      <= '0;
        qR[k]      <= '0;
      end
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_pkt_valid   <= 1'b0;
      o_pkt_header  <= '0;
      o_hdr_err     <= 1'b0;
      o_sub_err     <= '0;
      o_acr_valid   <= 1'b0;
      o_cts         <= '0;
      o_n           <= '0;
      o_audio_valid <= 1'b0;
      o_audio_l     <= '0;
      o_audio_r     <= '0;
    end else begin
      dataPrev      <= i_data;
      o_pkt_valid   <= 1'b0;
      o_acr_valid   <= 1'b0;
      o_audio_valid <= 1'b0;

      if (i_data) begin
        o_hsync <= i_d0[0];
        o_vsync <= i_d0[1];
      end

      if (!i_data)   live <= 1'b0;
      else if (rise) live <= 1'b1;

      if (active) begin
        pixCnt <= curPix;
        if (curPix < 5'd24) begin
          hdrBits[curPix] <= i_d0[2];
          hdrCode         <= hdrCodeNext;
        end else begin
          hdrPar <= {hdrPar[5:0], i_d0[2]};
        end
        for (int unsigned k = 0; k < 4; k++) begin
          if (curPix < 5'd28) begin
            subBits[k][{curPix, 1'b0}] <= i_d1[k];
            subBits[k][{curPix, 1'b1}] <= i_d2[k];
            subCode[k]                 <= subCodeNext[k];
          end else begin
            subPar[k] <= {subPar[k][3:0], i_d1[k], i_d2[k]};
          end
        end
      end

      if (lastPix) begin
        o_pkt_valid  <= 1'b1;
        o_pkt_header <= hdrBits;
        o_hdr_err    <= hdrErr;
        o_sub_err    <= subErr;
        if (isAcr) begin
          o_acr_valid <= 1'b1;
          o_cts       <= {subBits[0][11:8], subBits[0][23:16], subBits[0][31:24]};
          o_n         <= {subBits[0][35:32], subBits[0][47:40], subBits[0][55:48]};
        end
        for (int unsigned k = 0; k < 4; k++) begin
          qL[k] <= subBits[k][23:8];
          qR[k] <= subBits[k][47:32];
        end
      end

      if (lastPix)             qMask <= loadMask;
      else if (state == EMIT)  qMask <= maskAfter;

      if ((state == EMIT) && emitHit) begin
        o_audio_valid <= 1'b1;
        o_audio_l     <= qL[emitIdx];
        o_audio_r     <= qR[emitIdx];
      end
    end
  end

endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
module tb_hdmi_data_island_decoder;

  logic        i_pixclk = 1'b0;
  logic        i_reset  = 1'b1;
  logic        i_data   = 1'b0;
  logic [3:0]  i_d0 = '0, i_d1 = '0, i_d2 = '0;
  logic        o_hsync, o_vsync, o_pkt_valid, o_hdr_err, o_acr_valid, o_audio_valid;
  logic [23:0] o_pkt_header;
  logic [3:0]  o_sub_err;
  logic [19:0] o_cts, o_n;
  logic [15:0] o_audio_l, o_audio_r;

  hdmi_data_island_decoder #(.ACR_TYPE(8'h01), .AUDIO_TYPE(8'h02)) dut (
    .i_pixclk(i_pixclk), .i_reset(i_reset), .i_data(i_data),
    .i_d0(i_d0), .i_d1(i_d1), .i_d2(i_d2),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_pkt_valid(o_pkt_valid), .o_pkt_header(o_pkt_header),
    .o_hdr_err(o_hdr_err), .o_sub_err(o_sub_err),
    .o_acr_valid(o_acr_valid), .o_cts(o_cts), .o_n(o_n),
    .o_audio_valid(o_audio_valid), .o_audio_l(o_audio_l), .o_audio_r(o_audio_r)
  );

  always #5 i_pixclk = ~i_pixclk;

  int cyc = 0;
  always @(posedge i_pixclk) cyc <= cyc + 1;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    int          cyc;
    logic [23:0] hdr;
    logic        hdrErr;
    logic [3:0]  subErr;
    logic        acr;
    logic [19:0] cts;
    logic [19:0] n;
  } expPkt_t;

  typedef struct {
    int          cyc;
    logic [15:0] l;
    logic [15:0] r;
  } expAud_t;

  typedef struct {
    logic [23:0]       hdr;
    logic [3:0][55:0]  sub;
    int                flipHpar;
    int                flipSubK;
    int                flipSubBit;
  } pkt_t;

  expPkt_t pktQ[$];
  expAud_t audQ[$];
  expPkt_t ep;
  expAud_t ea;

  logic [23:0] lastHdr = '0;
  logic [19:0] lastCts = '0, lastN = '0;
  logic [3:0]  lastD0  = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    else nPass++;
  endtask

  // Reference BCH: serial LFSR over data bits in transmission order.
  function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
    logic [7:0] c = '0;
    for (int i = 0; i < n; i++)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 8'hC1 : 8'h00);
    return c;
  endfunction

  function automatic logic [7:0] sb(input logic [55:0] s, input int i);
    return s[8*i +: 8];
  endfunction

  function automatic pkt_t mkPkt(input logic [23:0] hdr, input logic [55:0] s0, s1, s2, s3);
    pkt_t p;
    p.hdr = hdr;
    p.sub[0] = s0; p.sub[1] = s1; p.sub[2] = s2; p.sub[3] = s3;
    p.flipHpar = -1; p.flipSubK = -1; p.flipSubBit = 0;
    return p;
  endfunction

  // Scoreboard monitor: compares whatever the DUT presents against the queues.
  always @(negedge i_pixclk) begin
    if (o_pkt_valid === 1'b1) begin
      if (pktQ.size() == 0) check("unexpectedPkt", o_pkt_valid, 0);
      else begin
        ep = pktQ.pop_front();
        check("pktCycle",  cyc,          ep.cyc);
        check("pktHeader", o_pkt_header, ep.hdr);
        check("hdrErr",    o_hdr_err,    ep.hdrErr);
        check("subErr",    o_sub_err,    ep.subErr);
        check("acrValid",  o_acr_valid,  ep.acr);
        check("cts",       o_cts,        ep.cts);
        check("n",         o_n,          ep.n);
      end
    end else if (o_acr_valid === 1'b1) begin
      check("strayAcr", o_acr_valid, 0);
    end
    if (o_audio_valid === 1'b1) begin
      if (audQ.size() == 0) check("unexpectedAudio", o_audio_valid, 0);
      else begin
        ea = audQ.pop_front();
        check("audioCycle", cyc,       ea.cyc);
        check("audioL",     o_audio_l, ea.l);
        check("audioR",     o_audio_r, ea.r);
      end
    end
  end

  task automatic drive(input logic dat, input logic [3:0] a, b, c, input logic rst);
    @(posedge i_pixclk);
    #1;
    i_data = dat; i_d0 = a; i_d1 = b; i_d2 = c; i_reset = rst;
    if (rst)      lastD0 = '0;
    else if (dat) lastD0 = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic end_island();
    idle(3);
    check("hsyncHold", o_hsync, lastD0[0]);
    check("vsyncHold", o_vsync, lastD0[1]);
  endtask

  // Transmits one packet; truncAt >= 0 stops before that pixel, rstAt >= 0
  // pulses reset on that pixel. Only complete, unreset packets set expectations.
  task automatic send_pkt(input pkt_t p, input int truncAt, input int rstAt);
    logic [7:0]       hpar;
    logic [3:0][7:0]  spar;
    logic [3:0][55:0] tx;
    logic [3:0]       d0, d1, d2;
    logic             hErr;
    logic [3:0]       sErr;
    logic [55:0]      s0;
    expPkt_t          e;
    expAud_t          a;
    int               j;
    hpar = bch({40'b0, p.hdr}, 24);
    hErr = 1'b0;
    if (p.flipHpar >= 0) begin
      hpar[p.flipHpar] = ~hpar[p.flipHpar];
      hErr = 1'b1;
    end
    tx = p.sub;
    sErr = '0;
    for (int k = 0; k < 4; k++) spar[k] = bch({8'b0, p.sub[k]}, 56);
    if (p.flipSubK >= 0) begin
      tx[p.flipSubK][p.flipSubBit] = ~tx[p.flipSubK][p.flipSubBit];
      sErr[p.flipSubK] = 1'b1;
    end
    for (int px = 0; px < 32; px++) begin
      if (px == truncAt) break;
      d0 = 4'($urandom);
      d0[2] = (px < 24) ? p.hdr[px] : hpar[31 - px];
      for (int k = 0; k < 4; k++) begin
        d1[k] = (px < 28) ? tx[k][2*px]     : spar[k][63 - 2*px];
        d2[k] = (px < 28) ? tx[k][2*px + 1] : spar[k][62 - 2*px];
      end
      drive(1'b1, d0, d1, d2, px == rstAt);
      if (px == rstAt) begin
        lastHdr = '0; lastCts = '0; lastN = '0;
      end
      if (px == 31 && truncAt < 0 && rstAt < 0) begin
        e.cyc    = cyc + 1;
        e.hdr    = p.hdr;
        e.hdrErr = hErr;
        e.subErr = sErr;
        e.acr    = (p.hdr[7:0] == 8'h01) && !hErr && !sErr[0];
        if (e.acr) begin
          s0 = tx[0];
          lastCts = {sb(s0, 1)[3:0], sb(s0, 2), sb(s0, 3)};
          lastN   = {sb(s0, 4)[3:0], sb(s0, 5), sb(s0, 6)};
        end
        e.cts = lastCts;
        e.n   = lastN;
        lastHdr = p.hdr;
        pktQ.push_back(e);
        if (p.hdr[7:0] == 8'h02 && !hErr) begin
          j = 0;
          for (int k = 0; k < 4; k++) begin
            if (p.hdr[8 + k] && !sErr[k]) begin
              a.cyc = cyc + 2 + j;
              a.l   = tx[k][23:8];
              a.r   = tx[k][47:32];
              audQ.push_back(a);
              j++;
            end
          end
        end
      end
    end
  endtask

  function automatic pkt_t randPkt();
    pkt_t p;
    int   t;
    logic [7:0] hb0;
    t = $urandom_range(0, 2);
    hb0 = (t == 0) ? 8'h01 : (t == 1) ? 8'h02 : 8'($urandom);
    p = mkPkt({16'($urandom), hb0},
              {24'($urandom), 32'($urandom)}, {24'($urandom), 32'($urandom)},
              {24'($urandom), 32'($urandom)}, {24'($urandom), 32'($urandom)});
    t = $urandom_range(0, 3);
    if (t == 0) p.flipHpar = $urandom_range(0, 7);
    if (t == 1) begin
      p.flipSubK   = $urandom_range(0, 3);
      p.flipSubBit = $urandom_range(0, 55);
    end
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [55:0] ACR_SUB0 = 56'h00180078690000;
  localparam logic [55:0] AUD_SUB0 = 56'h00ABCD00123400;
  localparam logic [55:0] AUD_SUB1 = 56'h00FFFF00000100;

  initial begin
    pkt_t p;
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    check("resetPktValid", o_pkt_valid, 0);
    check("resetOutputs",
          {o_hsync, o_vsync, o_pkt_header, o_hdr_err, o_sub_err, o_acr_valid, o_audio_valid},
          0);
    check("resetData", {o_cts, o_n, o_audio_l, o_audio_r}, 0);
    idle(4);

    // ACR: CTS 27000, N 6144
    send_pkt(mkPkt(24'h000001, ACR_SUB0, 56'h0, 56'h0, 56'h0), -1, -1);
    end_island();
    check("acrCtsValue", o_cts, 20'h06978);
    check("acrNValue",   o_n,   20'h01800);

    // Audio: two samples from subpackets 0 and 1
    send_pkt(mkPkt(24'h000302, AUD_SUB0, AUD_SUB1, 56'h0, 56'h0), -1, -1);
    end_island();
    idle(3);
    check("audioLHeld", o_audio_l, 16'h0001);
    check("audioRHeld", o_audio_r, 16'hFFFF);

    // Corrupted subpacket 1 data: only sub0 sample emitted
    p = mkPkt(24'h000302, AUD_SUB0, AUD_SUB1, 56'h0, 56'h0);
    p.flipSubK = 1; p.flipSubBit = 10;
    send_pkt(p, -1, -1);
    end_island();
    idle(3);
    check("audioLOnlySub0", o_audio_l, 16'h1234);
    check("subErrValue",    o_sub_err, 4'b0010);

    // Corrupted header parity: no audio
    p = mkPkt(24'h000302, AUD_SUB0, AUD_SUB1, 56'h0, 56'h0);
    p.flipHpar = 3;
    send_pkt(p, -1, -1);
    end_island();
    check("hdrErrValue", o_hdr_err, 1'b1);

    // Back-to-back ACR then audio in one island
    send_pkt(mkPkt(24'h000001, 56'h002001_40E20100, 56'h0, 56'h0, 56'h0), -1, -1);
    send_pkt(mkPkt(24'h000F02, AUD_SUB0, AUD_SUB1, 56'h00_5555_00_AAAA_00, 56'h00_0F0F_00_F0F0_00), -1, -1);
    end_island();
    idle(4);

    // Truncated island: nothing changes
    send_pkt(mkPkt(24'h000001, 56'h00_34_07_12_56_03_00, 56'h0, 56'h0, 56'h0), 20, -1);
    end_island();
    check("truncHeaderHeld", o_pkt_header, lastHdr);
    check("truncCtsHeld",    o_cts,        lastCts);
    check("truncNHeld",      o_n,          lastN);

    // Reset in the middle of an island, then a clean packet
    send_pkt(mkPkt(24'h000001, 56'h00_34_07_12_56_03_00, 56'h0, 56'h0, 56'h0), -1, 10);
    end_island();
    check("postResetHeader", o_pkt_header, 24'h0);
    check("postResetCts",    o_cts,        20'h0);
    send_pkt(mkPkt(24'h000001, 56'h00_34_07_12_56_03_00, 56'h0, 56'h0, 56'h0), -1, -1);
    end_island();
    check("recoverCts", o_cts, 20'h35612);

    // Randomized packets, some back-to-back
    for (int i = 0; i < 24; i++) begin
      send_pkt(randPkt(), -1, -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    end_island();
    idle(10);
    check("pktQueueDrained",   pktQ.size(), 0);
    check("audioQueueDrained", audQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/hdmi_data_island_decoder.md
HDMI_DATA_ISLAND_DECODER -- requirements
Module: hdmi_data_island_decoder

Interface
REQ-001 SHALL have parameter ACR_TYPE, default 8'h01, header byte 0 identifying an audio clock regeneration packet.
REQ-002 SHALL have parameter AUDIO_TYPE, default 8'h02, header byte 0 identifying an audio sample packet.
REQ-003 SHALL have port i_pixclk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_data, input, 1 bit: high during data-island pixels, already TERC4-decoded.
REQ-006 SHALL have ports i_d0, i_d1, i_d2, input, 4 bits each: the decoded nibbles of channels 0/1/2.
REQ-007 SHALL have ports o_hsync and o_vsync, output, 1 bit each: i_d0[0] and i_d0[1] registered while i_data=1; they hold their value otherwise.
REQ-008 SHALL have port o_pkt_valid, output, 1 bit: one-cycle strobe marking a completed packet.
REQ-009 SHALL have port o_pkt_header, output, 24 bits: received header with HB0 in [7:0].
REQ-010 SHALL have port o_hdr_err, output, 1 bit: header BCH mismatch.
REQ-011 SHALL have port o_sub_err, output, 4 bits: per-subpacket BCH mismatch.
REQ-012 SHALL have ports o_acr_valid (1 bit), o_cts (20 bits) and o_n (20 bits), outputs: ACR strobe and its values.
REQ-013 SHALL have ports o_audio_valid (1 bit), o_audio_l (16 bits) and o_audio_r (16 bits), outputs: one stereo sample per strobe.

Function
REQ-014 Per pixel of a packet, i_d0[2] SHALL carry 1 header bit, i_d1[k] SHALL carry the even bit of subpacket k, and i_d2[k] the odd bit of subpacket k; all bits are LSB-first.
REQ-015 A 5-bit pixel counter SHALL reset to 0 on the first cycle with i_data=1 after i_data=0, increment on each i_data=1 cycle, and wrap 31->0 so that back-to-back packets in one island are decoded.
REQ-016 Header: pixels 0-23 SHALL be data bits; pixels 24-31 SHALL be BCH parity, received in order p7..p0.
REQ-017 Subpacket: pixels 0-27 SHALL carry 56 data bits; pixels 28-31 SHALL carry parity, with p7,p6 on pixel 28 (d1,d2), p5,p4 on pixel 29, and so on.
REQ-018 BCH SHALL be an 8-bit LFSR, init 0, applied per data bit b in serial order: code = (code<<1) ^ ((code[7]^b) ? 8'hC1 : 0). Parity is not fed back.
REQ-019 Error flags SHALL be set when the received parity differs from the final LFSR value; subpackets SHALL process the even bit before the odd bit within each pixel.
REQ-020 o_pkt_valid SHALL pulse exactly 1 cycle after the pixel-31 capture, with o_pkt_header and the error flags valid and held until the next strobe.
REQ-021 If i_data falls before pixel 31, the partial packet SHALL be discarded: no strobes, and the previous outputs are held.
REQ-022 ACR: when HB0=ACR_TYPE, o_hdr_err=0 and o_sub_err[0]=0, o_acr_valid SHALL pulse in the same cycle as o_pkt_valid.
REQ-023 ACR fields from subpacket 0 bytes SB1-SB6: o_cts SHALL be {SB1[3:0],SB2,SB3} and o_n SHALL be {SB4[3:0],SB5,SB6}.
REQ-024 Audio: when HB0=AUDIO_TYPE and o_hdr_err=0, each subpacket k with HB1[k]=1 and o_sub_err[k]=0 SHALL be queued.
REQ-025 Queued samples SHALL be emitted one per cycle in ascending k, starting the cycle after o_pkt_valid, with o_audio_l = subpacket bits [23:8] and o_audio_r = subpacket bits [47:32].
REQ-026 The audio emitter SHALL be a 2-state FSM: IDLE -> EMIT on a queue load with a nonzero mask; EMIT -> IDLE when the mask empties; at most 4 cycles in EMIT.
REQ-027 Audio parity, channel-status and B-frame bits SHALL be ignored; audio data is passed as received.
REQ-028 All strobes SHALL be single-cycle; data outputs SHALL hold between strobes.

Reset
REQ-029 On i_reset=1, all outputs SHALL be 0 on the next edge, and the counter, LFSRs, shift registers and emitter queue SHALL clear; the FSM SHALL go to IDLE.
REQ-030 Reset asserted mid-packet or mid-emission SHALL abort that work with no strobe; decoding resumes on the next i_data rise after release.

Verification
REQ-031 ACR packet with CTS=27000 and N=6144, correct BCH -> o_acr_valid=1 with o_pkt_valid, o_cts=20'h06978, o_n=20'h01800, all error flags 0.
REQ-032 Audio packet with header 24'h000302, sub0 L=16'h1234 R=16'hABCD, sub1 L=16'h0001 R=16'hFFFF -> two consecutive o_audio_valid cycles with those pairs in order, starting the cycle after o_pkt_valid.
REQ-033 Same audio packet with one flipped data bit in sub1 -> o_sub_err=4'b0010 and only the sub0 sample emitted; a flipped header parity bit -> o_hdr_err=1 and no audio or ACR strobes.
REQ-034 Two back-to-back packets in one 64-pixel island (ACR then audio) -> o_pkt_valid exactly 32 cycles apart, both decoded correctly.
REQ-035 i_data dropped at pixel 20 -> no strobes and outputs unchanged; i_reset pulsed at pixel 10 of a following island -> no strobes, and the next full packet decodes correctly.
